row_config_loader: RTL and testbench
====================================

Name: row_config_loader

Overview:
Serial configuration loader for one routing row. It accepts a bitstream through a valid/ready handshake, assembles it in a shadow register, and commits the full word in one cycle to the row's brbselect bus. The output feeds the select input of the last-row routing block directly. It is double-buffered, so the fabric never sees a partially loaded configuration.

Parameters:
wire_width, 3, wires per routing channel (must match the downstream row)
fpga_width, 5, tiles per row (must match the downstream row)
CFG_BITS, fpga_width*wire_width*12, localparam; brbselect width (180 at defaults)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin or restart a load
cfg_bit  input  1  serial configuration data
cfg_valid  input  1  cfg_bit is valid this cycle
cfg_ready  output  1  loader accepts cfg_bit this cycle
brbselect  output  CFG_BITS  committed configuration, to the routing row's select input
busy  output  1  load in progress (LOAD or COMMIT)
done  output  1  one-cycle pulse on commit completion
err  output  1  sticky parity error; constant 0 unless CFG_PARITY_EN is defined

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; shadow, brbselect, bit counter and parity accumulator cleared to 0.
  - cfg_ready, busy, done and err all 0.
  - Reset wins over every other input, including mid-load; the partial load is discarded.
- Counter width is $clog2(CFG_BITS+2).
- A bit is accepted only when cfg_valid && cfg_ready at an edge.
- Shadow shifts right with the new bit entering at the MSB. After CFG_BITS accepts, the first bit sits at bit 0, so the stream is LSB-first.
- States:
  - IDLE:
    - cfg_ready=0 and busy=0; cfg_valid is ignored.
    - start=1 -> LOAD, with counter=0 and parity accumulator=0.
  - LOAD:
    - cfg_ready=1 and busy=1.
    - Each accept shifts the shadow, increments the counter and XORs the bit into the parity accumulator.
    - The accept that brings the counter to CFG_BITS (or CFG_BITS+1 with parity) moves to COMMIT.
    - start=1 in LOAD restarts the load: counter and parity cleared, any cfg_bit accepted that same cycle is discarded, brbselect unchanged.
    - Gaps in cfg_valid stall the load indefinitely without penalty.
  - COMMIT (one cycle):
    - cfg_ready=0 and busy=1; start is ignored.
    - At the next edge: brbselect<=shadow, done<=1, state<=IDLE.
- Latency: if the last bit is accepted at edge T, brbselect takes the new value and done=1 during the cycle after edge T+1. done lasts exactly one cycle. busy=0 in that same cycle.
- brbselect holds its previous value for the whole LOAD, and changes only at the COMMIT edge or on reset.
- start=1 on the same edge that leaves COMMIT is ignored. A start asserted in the done cycle is honoured.

Optional Feature:
Macro: CFG_PARITY_EN
- Defined:
  - LOAD accepts CFG_BITS+1 bits; the final bit is an even-parity bit over all CFG_BITS data bits.
  - The parity bit is not shifted into the shadow.
  - At COMMIT, if the XOR of all CFG_BITS+1 bits is 0: commit normally and err stays 0.
  - If the XOR is 1: brbselect is unchanged, err<=1, and done still pulses.
  - err is sticky; it is cleared by the next accepted start or by rst.
- Undefined: exactly CFG_BITS bits per load, no parity logic is present, and err is tied to 0.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> brbselect=0, cfg_ready=0, busy=0, done=0, err=0.
- Basic load (defaults): start, then 180 back-to-back bits with bit i = (i%3==0) -> brbselect[i]=1 exactly for i%3==0; done high for one cycle, 2 cycles after the last accept edge; busy low in that cycle.
- Handshake gaps:
  - First load all ones, then a second load of all zeros with cfg_valid randomly low ~50% of cycles.
  - -> brbselect stays all ones until the second commit, then 0.
  - Exactly 180 accepts are counted; cfg_valid in IDLE has no effect.
- Restart: start, 50 bits of 1, start again, 180 bits of 0 -> brbselect=0 after a single done pulse (no done at restart).
- Reset mid-load: commit pattern 0xAA.., begin a new load, assert rst after 100 bits -> brbselect=0, state IDLE; a following full load commits correctly.
- CFG_PARITY_EN:
  - 180 bits containing 7 ones plus parity bit 1 -> commit, err=0.
  - The same with parity bit 0 -> brbselect unchanged, err=1 and held.
  - A following start -> err=0.

Source files
------------

// File: rtl/row_config_loader.sv
// Serial, double-buffered configuration loader for one routing row.
// Ports: clk, rst, start, cfg_bit/cfg_valid/cfg_ready, brbselect, busy, done, err.
// Optional even-parity check when CFG_PARITY_EN is defined.
module row_config_loader #(
  parameter int wire_width = 3,
  parameter int fpga_width = 5,
  localparam int CFG_BITS = fpga_width * wire_width * 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cfg_bit,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [CFG_BITS-1:0] brbselect,
  output logic                busy,
  output logic                done,
  output logic                err
);

`ifdef CFG_PARITY_EN
  localparam int NBITS = CFG_BITS + 1;
`else
  localparam int NBITS = CFG_BITS;
`endif
  localparam int CW = $clog2(CFG_BITS + 2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       cnt_q;
  logic [CFG_BITS-1:0] shadow_q;
  logic                clr;
  logic                acc;
  logic                shift;
  logic                commit_ok;

  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    acc       = 1'b0;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          clr     = 1'b1;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        // a restart drops any bit offered in the same cycle
        if (start) begin
          clr = 1'b1;
        end else if (cfg_valid) begin
          acc = 1'b1;
          if (cnt_q == CW'(NBITS - 1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef CFG_PARITY_EN
  logic par_q;
  logic err_q;

  // the trailing parity bit is counted but never enters the shadow
  assign shift     = acc && (cnt_q != CW'(CFG_BITS));
  assign commit_ok = ~par_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (clr) begin
        par_q <= 1'b0;
        err_q <= 1'b0;
      end else if (acc) begin
        par_q <= par_q ^ cfg_bit;
      end
      if (state_q == COMMIT && par_q) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign shift     = acc;
  assign commit_ok = 1'b1;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      brbselect <= '0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == COMMIT);
      if (clr) begin
        cnt_q <= '0;
      end else if (acc) begin
        cnt_q <= cnt_q + CW'(1);
      end
      // LSB-first stream: newest bit enters at the MSB
      if (shift) begin
        shadow_q <= {cfg_bit, shadow_q[CFG_BITS-1:1]};
      end
      if (state_q == COMMIT && commit_ok) begin
        brbselect <= shadow_q;
      end
    end
  end

endmodule

// File: tb/tb_row_config_loader.sv
// Directed + randomized bench for row_config_loader.
// Expected row contents come from a bit-list model of each load.
module tb_row_config_loader;

  localparam int CFG_BITS = 180;
`ifdef CFG_PARITY_EN
  localparam int NB = CFG_BITS + 1;
`else
  localparam int NB = CFG_BITS;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                cfg_bit;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CFG_BITS-1:0] brbselect;
  logic                busy;
  logic                done;
  logic                err;

  int checks   = 0;
  int failures = 0;

  logic [CFG_BITS-1:0] exp_row;
  logic                exp_err;

  row_config_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .brbselect (brbselect),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [CFG_BITS-1:0] obs,
                     input logic [CFG_BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full load of d; gap = percent of cycles with cfg_valid low.
  task automatic do_load(input logic [CFG_BITS-1:0] d, input int gap,
                         input bit bad_par, input bit start_in_commit);
    int  n;
    bit  v;
    logic pbit;
    pbit      = (^d) ^ bad_par;
    start     = 1'b1;
    cfg_valid = 1'($urandom);
    cfg_bit   = 1'b1;
    tick();
    start   = 1'b0;
    exp_err = 1'b0;
    chk1("load_busy", busy, 1'b1);
    chk1("load_err_clr", err, exp_err);
    n = 0;
    while (n < NB) begin
      v         = ($urandom_range(99) >= gap);
      cfg_valid = v;
      cfg_bit   = (n < CFG_BITS) ? d[n] : pbit;
      chk1("load_ready", cfg_ready, 1'b1);
      chk1("load_nodone", done, 1'b0);
      chk("load_hold", brbselect, exp_row);
      tick();
      if (v) n++;
    end
    cfg_valid = 1'($urandom);
    start     = start_in_commit;
    chk1("commit_ready", cfg_ready, 1'b0);
    chk1("commit_busy", busy, 1'b1);
    chk1("commit_nodone", done, 1'b0);
    chk("commit_hold", brbselect, exp_row);
    tick();
    start     = 1'b0;
    cfg_valid = 1'b0;
    if (bad_par) exp_err = 1'b1;
    else exp_row = d;
    chk1("done_pulse", done, 1'b1);
    chk1("done_busy", busy, 1'b0);
    chk("done_row", brbselect, exp_row);
    chk1("done_err", err, exp_err);
    tick();
    chk1("done_once", done, 1'b0);
    chk1("idle_busy", busy, 1'b0);
  endtask

  function automatic logic [CFG_BITS-1:0] rnd_row();
    logic [CFG_BITS-1:0] r;
    for (int i = 0; i < CFG_BITS; i++) r[i] = 1'($urandom);
    return r;
  endfunction

  initial begin
    logic [CFG_BITS-1:0] d;
    int n;
    rst = 1'b1; start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
    exp_row = '0; exp_err = 1'b0;

    // reset with random inputs
    repeat (2) begin
      start     = 1'($urandom);
      cfg_valid = 1'($urandom);
      cfg_bit   = 1'($urandom);
      tick();
      chk("rst_row", brbselect, '0);
      chk1("rst_ready", cfg_ready, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
    end
    rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    tick();

    // basic: bit i set when i%3==0
    for (int i = 0; i < CFG_BITS; i++) d[i] = (i % 3 == 0);
    do_load(d, 0, 1'b0, 1'b0);

    // all ones, then idle traffic, then all zeros with gaps
    do_load('1, 0, 1'b0, 1'b1);
    repeat (5) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'($urandom);
      tick();
      chk1("idle_ready", cfg_ready, 1'b0);
      chk1("idle_busy2", busy, 1'b0);
      chk("idle_row", brbselect, exp_row);
    end
    cfg_valid = 1'b0;
    do_load('0, 50, 1'b0, 1'b0);

    // random data with gaps
    do_load(rnd_row(), 30, 1'b0, 1'b0);

    // restart after 50 ones, then 180 zeros
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (n < 50) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      tick();
      n++;
      chk1("restart_nodone", done, 1'b0);
    end
    do_load('0, 0, 1'b0, 1'b0);

    // reset mid-load
    for (int i = 0; i < CFG_BITS; i++) d[i] = (i % 2 == 1);
    do_load(d, 0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (n < 100) begin
      cfg_valid = 1'($urandom);
      cfg_bit   = 1'($urandom);
      tick();
      if (cfg_valid) n++;
    end
    cfg_valid = 1'b0;
    chk("midload_hold", brbselect, exp_row);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_row = '0;
    chk("midrst_row", brbselect, exp_row);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_ready", cfg_ready, 1'b0);
    tick();
    chk1("midrst_idle", busy, 1'b0);
    do_load(rnd_row(), 20, 1'b0, 1'b0);

`ifdef CFG_PARITY_EN
    d = '0;
    n = 0;
    while (n < 7) begin
      int p;
      p = $urandom_range(CFG_BITS - 1);
      if (!d[p]) begin
        d[p] = 1'b1;
        n++;
      end
    end
    do_load(d, 0, 1'b0, 1'b0);
    do_load(~d, 10, 1'b1, 1'b0);
    repeat (3) begin
      tick();
      chk1("err_sticky", err, 1'b1);
      chk("err_row", brbselect, exp_row);
    end
    do_load(rnd_row(), 10, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
